// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART host-command parser: FSM states,
// default header bytes, command ids used by the config registers, and
// the acknowledge byte constants.
package uart_cmd_parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CHK
  } state_t;

  localparam logic [7:0] HDR0_DEF        = 8'h55;
  localparam logic [7:0] HDR1_DEF        = 8'hAA;
  localparam int         MAX_LEN_DEF     = 8;
  localparam int         TIMEOUT_CYC_DEF = 25800;

  localparam logic [7:0] CMD_SET_THRESH  = 8'h01;
  localparam logic [7:0] CMD_SET_WINDOW  = 8'h02;

  localparam logic [7:0] ACK_OK_MASK     = 8'h80;
  localparam logic [7:0] ACK_ERR         = 8'hEE;

  // Ack byte returned to the host for an accepted command.
  function automatic logic [7:0] ack_for_cmd(input logic [7:0] id);
    return id ^ ACK_OK_MASK;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// uart_byte_timeout: inter-byte timeout as a loadable down-counter.
// The window restarts on every received byte and whenever the parser is
// idle; expire is raised on the last cycle of a full silent window,
// unless a byte arrives in that same cycle.
module uart_byte_timeout #(
  parameter int CYC = 25800
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int              W    = $clog2(CYC + 1);
  localparam logic [W-1:0]    LOAD = W'(CYC - 1);

  logic [W-1:0] cnt;

  // Reload on each byte or while idle, otherwise count down to terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= LOAD;
    end else if (clear || !run) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && !clear && (cnt == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes framed host commands from the UART receive
// byte stream: HDR0 HDR1 CMD LEN P0..P(LEN-1) CHK, CHK = CMD+LEN+sum(P).
// Good frames give a one-cycle cmd_valid with held id/len/payload; bad
// frames give one-cycle error pulses and bump a saturating err_cnt.
// Optional build macro UART_CMD_ACK_EN adds a one-deep acknowledge path
// (tx_busy in, ack_data/ack_en out).
//
// state  | meaning
// S_IDLE | hunting for HDR0
// S_HDR1 | HDR0 seen, expecting HDR1 (repeated HDR0 resyncs here)
// S_CMD  | next byte is the command id
// S_LEN  | next byte is the payload length
// S_PAY  | collecting payload bytes
// S_CHK  | next byte is the checksum
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int         MAX_LEN     = MAX_LEN_DEF,
  parameter logic [7:0] HDR0        = HDR0_DEF,
  parameter logic [7:0] HDR1        = HDR1_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_en,
`ifdef UART_CMD_ACK_EN
  input  logic                   tx_busy,
  output logic [7:0]             ack_data,
  output logic                   ack_en,
`endif
  output logic                   cmd_valid,
  output logic [7:0]             cmd_id,
  output logic [4:0]             cmd_len,
  output logic [MAX_LEN*8-1:0]   cmd_payload,
  output logic                   err_chk,
  output logic                   err_len,
  output logic                   err_timeout,
  output logic [7:0]             err_cnt
);

  state_t                    state;
  logic [7:0]                cmd_cur;
  logic [7:0]                sum;
  logic [4:0]                len;
  logic [3:0]                idx;
  logic [MAX_LEN-1:0][7:0]   pay_buf;
  logic                      expire;
  logic                      good_d;
  logic                      bad_chk_d;
  logic                      bad_len_d;
  logic                      any_err_d;

  uart_byte_timeout #(.CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_en),
    .run    (state != S_IDLE),
    .expire (expire)
  );

  // Decide frame outcome for the byte being presented this cycle.
  always_comb begin
    good_d    = 1'b0;
    bad_chk_d = 1'b0;
    bad_len_d = 1'b0;
    if (rx_en) begin
      case (state)
        S_LEN:   bad_len_d = (rx_data > 8'(MAX_LEN));
        S_CHK: begin
          good_d    = (rx_data == sum);
          bad_chk_d = (rx_data != sum);
        end
        default: ;
      endcase
    end
    any_err_d = bad_chk_d | bad_len_d | expire;
  end

  // Frame FSM, payload buffer and registered command/error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cmd_cur     <= '0;
      sum         <= '0;
      len         <= '0;
      idx         <= '0;
      pay_buf     <= '0;
      cmd_valid   <= 1'b0;
      cmd_id      <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_cnt     <= '0;
    end else begin
      cmd_valid   <= good_d;
      err_chk     <= bad_chk_d;
      err_len     <= bad_len_d;
      err_timeout <= expire;
      if (any_err_d && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (good_d) begin
        cmd_id      <= cmd_cur;
        cmd_len     <= len;
        cmd_payload <= pay_buf;
      end

      if (expire) begin
        state <= S_IDLE;
      end else if (rx_en) begin
        case (state)
          S_IDLE: begin
            if (rx_data == HDR0) state <= S_HDR1;
          end
          S_HDR1: begin
            if (rx_data == HDR1)      state <= S_CMD;
            else if (rx_data != HDR0) state <= S_IDLE;
          end
          S_CMD: begin
            cmd_cur <= rx_data;
            sum     <= rx_data;
            pay_buf <= '0;
            idx     <= '0;
            state   <= S_LEN;
          end
          S_LEN: begin
            if (bad_len_d) begin
              state <= S_IDLE;
            end else begin
              len   <= rx_data[4:0];
              sum   <= sum + rx_data;
              state <= (rx_data == 8'd0) ? S_CHK : S_PAY;
            end
          end
          S_PAY: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx == i[3:0]) pay_buf[i] <= rx_data;
            end
            idx <= idx + 4'd1;
            sum <= sum + rx_data;
            if ({1'b0, idx} == (len - 5'd1)) state <= S_CHK;
          end
          S_CHK:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_CMD_ACK_EN
  logic       ack_pend;
  logic [7:0] ack_val;

  // One-entry ack slot: send when the transmitter is free, newest wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_pend <= 1'b0;
      ack_val  <= '0;
      ack_en   <= 1'b0;
      ack_data <= '0;
    end else begin
      ack_en <= 1'b0;
      if (ack_pend && !tx_busy) begin
        ack_en   <= 1'b1;
        ack_data <= ack_val;
        ack_pend <= 1'b0;
      end
      if (cmd_valid || err_chk) begin
        ack_pend <= 1'b1;
        ack_val  <= cmd_valid ? ack_for_cmd(cmd_id) : ACK_ERR;
      end
    end
  end
`endif

endmodule
